nn_layer_mac: RTL and testbench

- Sequential multiply-accumulate engine for one fully connected layer of the classifier.
- Launched by the network controller's per-layer load strobe; returns the layer-done pulse the controller waits on.
- Reads input activations, weights and biases through 1-cycle-latency synchronous read ports.
- Writes one quantised activation per neuron into the next layer's buffer.
- One instance per hidden/output layer.

---
 rtl/nn_pkg.sv | 28 ++
 rtl/nn_layer_mac_if.sv | 40 ++++
 rtl/nn_activation.sv | 41 ++++
 rtl/nn_layer_mac.sv | 121 ++++++++++++
 tb/tb_nn_layer_mac.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the classifier layers: default datapath widths,
// layer sizes agreed with the network controller, and the MAC state encoding.
package nn_pkg;

  // Default datapath widths
  localparam int NN_DW      = 8;
  localparam int NN_ACC_W   = 24;
  localparam int NN_SHIFT   = 7;

  // Network geometry shared with the controller
  localparam int NN_INPUTS  = 62;
  localparam int NN_HIDDEN  = 30;
  localparam int NN_SAMPLES = 750;

  // Layer MAC state encoding
  typedef logic [2:0] nn_state_t;
  localparam nn_state_t ST_IDLE  = 3'd0;
  localparam nn_state_t ST_ADDR  = 3'd1;
  localparam nn_state_t ST_MAC   = 3'd2;
  localparam nn_state_t ST_WRITE = 3'd3;
  localparam nn_state_t ST_DONE  = 3'd4;

  // Address width for an n-entry memory, never narrower than one bit
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_layer_mac_if.sv
// Layer port bundle: launch/done handshake plus the activation, weight,
// bias read ports and the result write port.
// slave  : the layer MAC engine.
// master : the controller / memory side.
interface nn_layer_mac_if
  import nn_pkg::*;
#(
  parameter int N_IN  = NN_INPUTS,
  parameter int N_OUT = NN_HIDDEN,
  parameter int DW    = NN_DW
);

  localparam int XAW = addr_w(N_IN);
  localparam int WAW = addr_w(N_IN * N_OUT);
  localparam int OAW = addr_w(N_OUT);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [XAW-1:0]        x_addr;
  logic signed [DW-1:0]  x_data;
  logic [WAW-1:0]        w_addr;
  logic signed [DW-1:0]  w_data;
  logic [OAW-1:0]        b_addr;
  logic signed [DW-1:0]  b_data;
  logic                  y_we;
  logic [OAW-1:0]        y_addr;
  logic signed [DW-1:0]  y_data;

  modport master (
    output start, x_data, w_data, b_data,
    input  busy, done, x_addr, w_addr, b_addr, y_we, y_addr, y_data
  );

  modport slave (
    input  start, x_data, w_data, b_data,
    output busy, done, x_addr, w_addr, b_addr, y_we, y_addr, y_data
  );

endinterface

// File: rtl/nn_activation.sv
// Activation: arithmetic right shift of the accumulator followed by a clamp
// into the DW-bit result range.
// Build option NN_LAYER_RELU_EN selects a ReLU clamp [0, 2^(DW-1)-1];
// without it the result saturates to the full signed range (output layer).
module nn_activation
  import nn_pkg::*;
#(
  parameter int DW    = NN_DW,
  parameter int ACC_W = NN_ACC_W,
  parameter int SHIFT = NN_SHIFT
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [DW-1:0]    y
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'((2 ** (DW - 1)) - 1);
`ifndef NN_LAYER_RELU_EN
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(-(2 ** (DW - 1)));
`endif

  logic signed [ACC_W-1:0] shifted;

  function automatic logic signed [DW-1:0] clamp(input logic signed [ACC_W-1:0] a);
`ifdef NN_LAYER_RELU_EN
    if (a[ACC_W-1]) return '0;
    if (a > HI) return HI[DW-1:0];
    return a[DW-1:0];
`else
    if (a > HI) return HI[DW-1:0];
    if (a < LO) return LO[DW-1:0];
    return a[DW-1:0];
`endif
  endfunction

  // Scale down and clamp into the result range
  always_comb begin
    shifted = acc >>> SHIFT;
    y       = clamp(shifted);
  end

endmodule

// File: rtl/nn_layer_mac.sv
// Fully connected layer engine: one multiply-accumulate per cycle over
// N_IN inputs for each of N_OUT neurons, bias preloaded on the first term,
// result quantised by nn_activation and written to the next layer buffer.
// Build option NN_LAYER_RELU_EN (in nn_activation) picks ReLU vs saturation.
module nn_layer_mac
  import nn_pkg::*;
#(
  parameter int N_IN  = NN_INPUTS,
  parameter int N_OUT = NN_HIDDEN,
  parameter int DW    = NN_DW,
  parameter int ACC_W = NN_ACC_W,
  parameter int SHIFT = NN_SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  nn_layer_mac_if.slave  bus
);

  localparam int KW  = addr_w(N_IN);
  localparam int JW  = addr_w(N_OUT);
  localparam int WAW = addr_w(N_IN * N_OUT);

  localparam logic [KW-1:0]  K_LAST  = KW'(N_IN - 1);
  localparam logic [JW-1:0]  J_LAST  = JW'(N_OUT - 1);
  localparam logic [WAW-1:0] N_IN_WA = WAW'(N_IN);

  nn_state_t               state;
  logic [KW-1:0]           k;
  logic [JW-1:0]           j;
  logic signed [ACC_W-1:0] acc;

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] base;
  logic [KW-1:0]           k_next;
  logic [WAW-1:0]          w_base;
  logic signed [DW-1:0]    act_y;

  // Datapath terms: full-width product, bias or running sum, lookahead index
  always_comb begin
    prod   = bus.x_data * bus.w_data;
    base   = (k == '0) ? ACC_W'(bus.b_data) : acc;
    k_next = (k == K_LAST) ? k : k + 1'b1;
    w_base = WAW'(j) * N_IN_WA;
  end

  nn_activation #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_act (
    .acc (acc),
    .y   (act_y)
  );

  // Layer sequencer: neuron loop (j) around the input loop (k)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) state <= ST_ADDR;
        end
        ST_ADDR: begin
          k     <= '0;
          state <= ST_MAC;
        end
        ST_MAC: begin
          acc <= base + ACC_W'(prod);
          if (k == K_LAST) state <= ST_WRITE;
          else             k     <= k + 1'b1;
        end
        ST_WRITE: begin
          if (j == J_LAST) begin
            state <= ST_DONE;
          end else begin
            j     <= j + 1'b1;
            state <= ST_ADDR;
          end
        end
        ST_DONE: begin
          j     <= '0;
          k     <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status, read addresses and result port decoded from the current state
  always_comb begin
    bus.busy   = (state == ST_ADDR) || (state == ST_MAC) || (state == ST_WRITE);
    bus.done   = (state == ST_DONE);
    bus.y_we   = (state == ST_WRITE);
    bus.x_addr = '0;
    bus.w_addr = '0;
    bus.b_addr = '0;
    bus.y_addr = '0;
    bus.y_data = '0;
    case (state)
      ST_ADDR: begin
        bus.b_addr = j;
        bus.w_addr = w_base;
      end
      ST_MAC: begin
        bus.x_addr = k_next;
        bus.w_addr = w_base + WAW'(k_next);
      end
      ST_WRITE: begin
        bus.y_addr = j;
        bus.y_data = act_y;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_mac.sv
// Bench for nn_layer_mac with N_IN=4, N_OUT=2: one instance at SHIFT=0 and
// one at SHIFT=7 share the activation/weight/bias memory contents.
// Expected values depend on NN_LAYER_RELU_EN.
module tb_nn_layer_mac;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int NCYC  = 30;
  localparam int NVEC  = 10;

`ifdef NN_LAYER_RELU_EN
  localparam logic [7:0] E_M200 = 8'h00;
  localparam logic [7:0] E_M1   = 8'h00;
  localparam logic [7:0] E_M85  = 8'h00;
  localparam logic [7:0] E_M128 = 8'h00;
`else
  localparam logic [7:0] E_M200 = 8'h80;
  localparam logic [7:0] E_M1   = 8'hFF;
  localparam logic [7:0] E_M85  = 8'hAB;
  localparam logic [7:0] E_M128 = 8'h80;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  nn_layer_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus0 ();
  nn_layer_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus7 ();

  nn_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .SHIFT(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  nn_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .SHIFT(7))
    u_dut7 (.clk(clk), .rst(rst), .bus(bus7));

  logic signed [7:0] x_mem [N_IN];
  logic signed [7:0] w_mem [N_IN*N_OUT];
  logic signed [7:0] b_mem [N_OUT];

  // 1-cycle synchronous read ports
  always @(posedge clk) begin
    bus0.x_data <= x_mem[bus0.x_addr];
    bus0.w_data <= w_mem[bus0.w_addr];
    bus0.b_data <= b_mem[bus0.b_addr];
    bus7.x_data <= x_mem[bus7.x_addr];
    bus7.w_data <= w_mem[bus7.w_addr];
    bus7.b_data <= b_mem[bus7.b_addr];
  end

  // Observation mux over the instance under test
  logic       sel_r;
  logic       m_busy, m_done, m_we, m_ya, m_ba, m_zero;
  logic [1:0] m_xa;
  logic [2:0] m_wa;
  logic [7:0] m_yd;
  assign m_busy = sel_r ? bus7.busy   : bus0.busy;
  assign m_done = sel_r ? bus7.done   : bus0.done;
  assign m_we   = sel_r ? bus7.y_we   : bus0.y_we;
  assign m_ya   = sel_r ? bus7.y_addr : bus0.y_addr;
  assign m_ba   = sel_r ? bus7.b_addr : bus0.b_addr;
  assign m_xa   = sel_r ? bus7.x_addr : bus0.x_addr;
  assign m_wa   = sel_r ? bus7.w_addr : bus0.w_addr;
  assign m_yd   = sel_r ? bus7.y_data : bus0.y_data;
  assign m_zero = !(m_busy || m_done || m_we) && (m_ya == '0) && (m_ba == '0)
                  && (m_xa == '0) && (m_wa == '0) && (m_yd == '0);

  // Per-cycle log of one run; index n is cycle T+n
  logic       busy_l [0:NCYC];
  logic       done_l [0:NCYC];
  logic       we_l   [0:NCYC];
  logic       ya_l   [0:NCYC];
  logic       zero_l [0:NCYC];
  logic [1:0] xa_l   [0:NCYC];
  logic [2:0] wa_l   [0:NCYC];
  logic [7:0] yd_l   [0:NCYC];
  int         n_we, n_done;

  int pass_cnt, total_cnt;

  typedef struct packed {
    logic            sel;
    logic [3:0][7:0] x;
    logic [7:0][7:0] w;
    logic [1:0][7:0] b;
    logic [1:0][7:0] y;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk_uni(input logic sel, input logic signed [7:0] xv,
                                  input logic signed [7:0] w0, input logic signed [7:0] w1,
                                  input logic signed [7:0] b0, input logic signed [7:0] b1,
                                  input logic [7:0] y0, input logic [7:0] y1);
    vec_t v;
    v.sel = sel;
    v.x   = {4{xv}};
    v.w   = {{4{w1}}, {4{w0}}};
    v.b   = {b1, b0};
    v.y   = {y1, y0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < N_IN; i++)         x_mem[i] = v.x[i];
    for (int i = 0; i < N_IN * N_OUT; i++) w_mem[i] = v.w[i];
    for (int i = 0; i < N_OUT; i++)        b_mem[i] = v.b[i];
  endtask

  task automatic drive_start(input logic sel, input logic val);
    bus0.start = !sel && val;
    bus7.start = sel && val;
  endtask

  // Launch at cycle T and log NCYC cycles; optional extra start pulse,
  // start held for cycles 1..hold_until, reset pulse at cycle rst_at
  task automatic run(input logic sel, input int hold_until, input int restart_at,
                     input int rst_at);
    sel_r  = sel;
    n_we   = 0;
    n_done = 0;
    @(posedge clk); #1;
    drive_start(sel, 1'b1);
    @(posedge clk); #1;
    for (int n = 1; n <= NCYC; n++) begin
      rst = (n == rst_at) ? 1'b0 : 1'b1;
      drive_start(sel, (n <= hold_until) || (n == restart_at));
      @(negedge clk);
      busy_l[n] = m_busy;
      done_l[n] = m_done;
      we_l[n]   = m_we;
      ya_l[n]   = m_ya;
      zero_l[n] = m_zero;
      xa_l[n]   = m_xa;
      wa_l[n]   = m_wa;
      yd_l[n]   = m_yd;
      if (m_we)   n_we++;
      if (m_done) n_done++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive_start(sel, 1'b0);
  endtask

  task automatic check_busy(input string name, input int a1, input int b1,
                            input int a2, input int b2);
    int bad;
    bad = 0;
    for (int n = 1; n <= NCYC; n++) begin
      if (busy_l[n] !== ((n >= a1 && n <= b1) || (n >= a2 && n <= b2))) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    sel_r     = 1'b0;
    bus0.start = 1'b0;
    bus7.start = 1'b0;
    for (int i = 0; i < N_IN; i++)         x_mem[i] = '0;
    for (int i = 0; i < N_IN * N_OUT; i++) w_mem[i] = '0;
    for (int i = 0; i < N_OUT; i++)        b_mem[i] = '0;

    vecs[0] = mk_uni(1'b0, 8'sd1,    8'sd1,   8'sd1,   8'sd0,   8'sd0,  8'd4,   8'd4);
    vecs[1] = mk_uni(1'b0, 8'sd10,  -8'sd5,  -8'sd5,   8'sd0,   8'sd0,  E_M200, E_M200);
    vecs[2] = mk_uni(1'b0, 8'sd100,  8'sd100, 8'sd100, 8'sd0,   8'sd0,  8'd127, 8'd127);
    vecs[3] = mk_uni(1'b1, 8'sd16,   8'sd16,  8'sd16,  8'sd3,   8'sd3,  8'd8,   8'd8);
    vecs[4] = mk_uni(1'b1, 8'sd0,    8'sd5,   8'sd5,   8'sh80,  8'sh80, E_M1,   E_M1);
    vecs[5] = mk_uni(1'b0, 8'sd3,    8'sd2,  -8'sd7,   8'sd5,  -8'sd1,  8'd29,  E_M85);
    vecs[6] = mk_uni(1'b0, 8'sh80,   8'sh80,  8'sh80,  8'sd0,   8'sd0,  8'd127, 8'd127);
    vecs[7] = mk_uni(1'b0, 8'sd31,   8'sd1,  -8'sd1,   8'sd3,  -8'sd4,  8'd127, E_M128);
    vecs[8].sel = 1'b0;
    vecs[8].x   = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
    vecs[8].w   = {8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd4, 8'sd3, 8'sd2, 8'sd1};
    vecs[8].b   = {-8'sd2, 8'sd0};
    vecs[8].y   = {8'd18, 8'd30};
    vecs[9] = mk_uni(1'b1, 8'sd100,  8'sd100, 8'sd100, 8'sd0,   8'sd0,  8'd127, 8'd127);

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    sel_r = 1'b0;
    #1 check("reset_outputs_shift0", m_zero, 1);
    sel_r = 1'b1;
    #1 check("reset_outputs_shift7", m_zero, 1);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      load(vecs[i]);
      run(vecs[i].sel, 0, 0, 0);
      check($sformatf("v%0d_we_count", i), n_we, 2);
      check($sformatf("v%0d_y0", i), {we_l[6], ya_l[6], yd_l[6]}, {1'b1, 1'b0, vecs[i].y[0]});
      check($sformatf("v%0d_y1", i), {we_l[12], ya_l[12], yd_l[12]}, {1'b1, 1'b1, vecs[i].y[1]});
      check($sformatf("v%0d_done", i), {n_done[7:0], done_l[13]}, {8'd1, 1'b1});
      if (i == 0) begin
        check_busy("v0_busy_profile", 1, 12, 0, -1);
        check("v0_xaddr_hold_last", xa_l[5], 3);
        check("v0_waddr_n1_base", wa_l[7], 4);
        check("v0_waddr_n1_hold_last", wa_l[11], 7);
      end
    end

    // Second start while busy is ignored
    load(vecs[0]);
    run(1'b0, 0, 5, 0);
    check("busy_start_we_count", n_we, 2);
    check("busy_start_done", {n_done[7:0], done_l[13]}, {8'd1, 1'b1});
    check_busy("busy_start_profile", 1, 12, 0, -1);

    // Reset mid-layer, then relaunch at cycle 10
    run(1'b0, 0, 10, 8);
    check("abort_outputs_zero", zero_l[8], 1);
    check_busy("abort_busy_profile", 1, 7, 11, 22);
    check("abort_we_count", n_we, 3);
    check("abort_relaunch_y0", {we_l[16], ya_l[16], yd_l[16]}, {1'b1, 1'b0, 8'd4});
    check("abort_relaunch_y1", {we_l[22], ya_l[22], yd_l[22]}, {1'b1, 1'b1, 8'd4});
    check("abort_done", {n_done[7:0], done_l[23]}, {8'd1, 1'b1});

    // Start held high through DONE relaunches from IDLE
    run(1'b0, 14, 0, 0);
    check("hold_we_count", n_we, 4);
    check("hold_done", {n_done[7:0], done_l[13], done_l[27]}, {8'd2, 1'b1, 1'b1});
    check("hold_relaunch_y0", {we_l[20], ya_l[20], yd_l[20]}, {1'b1, 1'b0, 8'd4});
    check("hold_relaunch_y1", {we_l[26], ya_l[26], yd_l[26]}, {1'b1, 1'b1, 8'd4});
    check_busy("hold_busy_profile", 1, 12, 15, 26);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
